// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS-lite datapath.
// The controller (master) reads the IR contents and ALU zero flag and drives every enable and select.
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        PCWr;
    logic        IRWr;
    logic        RegWr;
    logic        MemWr;
    logic [1:0]  EXTctrl;
    logic        ALUSrcB;
    logic [2:0]  ALUctrl;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  NPCsel;
    logic [2:0]  state;
    logic        halt;

    modport master (
        input  instr, zero,
        output PCWr, IRWr, RegWr, MemWr, EXTctrl, ALUSrcB, ALUctrl,
               RegDst, MemtoReg, NPCsel, state, halt
    );

    modport slave (
        output instr, zero,
        input  PCWr, IRWr, RegWr, MemWr, EXTctrl, ALUSrcB, ALUctrl,
               RegDst, MemtoReg, NPCsel, state, halt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite datapath (FETCH/DECODE/EXE/MEM/WB/HALT).
// Define MC_ILLEGAL_HALT_EN to trap undecoded instructions in HALT; otherwise they run as a 2-cycle nop.
module mc_ctrl (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_instr_bits;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
    logic is_legal;

    logic [1:0] ext_sel;

    logic       pc_wr, ir_wr, reg_wr, mem_wr;
    logic [1:0] ext_ctrl;
    logic       alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] reg_dst, mem_to_reg, npc_sel;

    assign op                = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    assign is_rtype = (op == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (op == 6'b001101);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_lui   = (op == 6'b001111);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw |
                      is_beq | is_lui | is_j | is_jal;

    // Extender mode is a pure function of the opcode, so it stays put from EXE through WB.
    always_comb begin
        ext_sel = 2'b00;
        if (is_lui)
            ext_sel = 2'b10;
        else if (is_lw || is_sw)
            ext_sel = 2'b01;
        else if (is_beq)
            ext_sel = 2'b11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        ext_ctrl   = 2'b00;
        alu_src_b  = 1'b0;
        alu_ctrl   = 3'b000;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        npc_sel    = 2'b00;
        case (state_q)
            FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                    state_d = FETCH;
                end else if (is_jal) begin
                    // PC already holds PC+4 here, which is the link value written to $31.
                    pc_wr      = 1'b1;
                    npc_sel    = 2'b10;
                    reg_wr     = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    state_d    = FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b11;
                    state_d = FETCH;
                end else if (!is_legal) begin
`ifdef MC_ILLEGAL_HALT_EN
                    state_d = HALT;
`else
                    state_d = FETCH;
`endif
                end else begin
                    state_d = EXE;
                end
            end
            EXE: begin
                ext_ctrl = ext_sel;
                if (is_subu) begin
                    alu_ctrl = 3'b001;
                end else if (is_ori) begin
                    alu_ctrl  = 3'b010;
                    alu_src_b = 1'b1;
                end else if (is_lui) begin
                    alu_ctrl  = 3'b011;
                    alu_src_b = 1'b1;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 1'b1;
                end else if (is_beq) begin
                    alu_ctrl = 3'b001;
                    npc_sel  = 2'b01;
                    pc_wr    = bus.zero;
                end
                if (is_beq)
                    state_d = FETCH;
                else if (is_lw || is_sw)
                    state_d = MEM;
                else
                    state_d = WB;
            end
            MEM: begin
                ext_ctrl = ext_sel;
                mem_wr   = is_sw;
                state_d  = is_lw ? WB : FETCH;
            end
            WB: begin
                ext_ctrl = ext_sel;
                reg_wr   = 1'b1;
                if (is_rtype)
                    reg_dst = 2'b01;
                if (is_lw)
                    mem_to_reg = 2'b01;
                state_d = FETCH;
            end
            HALT: begin
`ifdef MC_ILLEGAL_HALT_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset gates the enables combinationally so an aborted store drops MemWr immediately.
    assign bus.PCWr     = pc_wr  & ~reset;
    assign bus.IRWr     = ir_wr  & ~reset;
    assign bus.RegWr    = reg_wr & ~reset;
    assign bus.MemWr    = mem_wr & ~reset;
    assign bus.EXTctrl  = ext_ctrl;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUctrl  = alu_ctrl;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.NPCsel   = npc_sel;
    assign bus.state    = state_q;

`ifdef MC_ILLEGAL_HALT_EN
    assign bus.halt = (state_q == HALT);
`else
    assign bus.halt = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed test-plan cases plus a random instruction stream
// checked cycle by cycle against a phase-table model of each instruction class.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic [1:0] ext;
        logic       srcb;
        logic [2:0] aluc;
        logic [1:0] regdst;
        logic [1:0] m2r;
        logic [1:0] npc;
        logic       hlt;
    } out_t;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9, C_BAD = 10;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int classify(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return C_ADDU;
                    6'b100011: return C_SUBU;
                    6'b001000: return C_JR;
                    default:   return C_BAD;
                endcase
            end
            6'b001101: return C_ORI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b001111: return C_LUI;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic logic [1:0] ext_of(input int cls);
        case (cls)
            C_LUI:       return 2'b10;
            C_LW, C_SW:  return 2'b01;
            C_BEQ:       return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    // Expected controls for one instruction class in one phase, straight from the phase tables.
    function automatic out_t exp_out(input int cls, input int ph, input logic z);
        out_t o;
        o = '0;
        o.st = 3'(ph);
        case (ph)
            P_F: begin
                o.pcwr = 1'b1;
                o.irwr = 1'b1;
            end
            P_D: begin
                if (cls == C_J || cls == C_JAL) begin
                    o.pcwr = 1'b1;
                    o.npc  = 2'b10;
                end
                if (cls == C_JAL) begin
                    o.regwr  = 1'b1;
                    o.regdst = 2'b10;
                    o.m2r    = 2'b10;
                end
                if (cls == C_JR) begin
                    o.pcwr = 1'b1;
                    o.npc  = 2'b11;
                end
            end
            P_E: begin
                o.ext = ext_of(cls);
                case (cls)
                    C_SUBU: o.aluc = 3'b001;
                    C_ORI:  begin o.aluc = 3'b010; o.srcb = 1'b1; end
                    C_LUI:  begin o.aluc = 3'b011; o.srcb = 1'b1; end
                    C_LW, C_SW: o.srcb = 1'b1;
                    C_BEQ:  begin o.aluc = 3'b001; o.npc = 2'b01; o.pcwr = z; end
                    default: ;
                endcase
            end
            P_M: begin
                o.ext   = ext_of(cls);
                o.memwr = (cls == C_SW);
            end
            P_W: begin
                o.ext   = ext_of(cls);
                o.regwr = 1'b1;
                if (cls == C_ADDU || cls == C_SUBU) o.regdst = 2'b01;
                if (cls == C_LW) o.m2r = 2'b01;
            end
            P_H: o.hlt = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.st     = bus.state;
        o.pcwr   = bus.PCWr;
        o.irwr   = bus.IRWr;
        o.regwr  = bus.RegWr;
        o.memwr  = bus.MemWr;
        o.ext    = bus.EXTctrl;
        o.srcb   = bus.ALUSrcB;
        o.aluc   = bus.ALUctrl;
        o.regdst = bus.RegDst;
        o.m2r    = bus.MemtoReg;
        o.npc    = bus.NPCsel;
        o.hlt    = bus.halt;
        return o;
    endfunction

    function automatic logic [31:0] gen_instr(input int cls);
        logic [31:0] w;
        w = $urandom;
        case (cls)
            C_ADDU: begin w[31:26] = 6'b000000; w[5:0] = 6'b100001; end
            C_SUBU: begin w[31:26] = 6'b000000; w[5:0] = 6'b100011; end
            C_JR:   begin w[31:26] = 6'b000000; w[5:0] = 6'b001000; end
            C_ORI:  w[31:26] = 6'b001101;
            C_LW:   w[31:26] = 6'b100011;
            C_SW:   w[31:26] = 6'b101011;
            C_BEQ:  w[31:26] = 6'b000100;
            C_LUI:  w[31:26] = 6'b001111;
            C_J:    w[31:26] = 6'b000010;
            C_JAL:  w[31:26] = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) w[31:26] = 6'b000000;
                while (classify(w) != C_BAD) w[5:0] = 6'($urandom);
            end
        endcase
        return w;
    endfunction

    // Runs one instruction from its FETCH cycle; entered in the cycle before FETCH (or just after reset release).
    task automatic run_instr(input logic [31:0] ins, input string name, input int limit);
        int   cls;
        int   ph[$];
        out_t exp;
        out_t got;
        logic z;
        cls = classify(ins);
        ph  = {P_F, P_D};
        case (cls)
            C_BEQ: ph.push_back(P_E);
            C_SW:  begin ph.push_back(P_E); ph.push_back(P_M); end
            C_LW:  begin ph.push_back(P_E); ph.push_back(P_M); ph.push_back(P_W); end
            C_ADDU, C_SUBU, C_ORI, C_LUI: begin ph.push_back(P_E); ph.push_back(P_W); end
            default: ;
        endcase
        for (int i = 0; i < ph.size() && i < limit; i++) begin
            @(negedge clk);
            if (i == 0) bus.instr = ins;
            z = 1'($urandom);
            bus.zero = z;
            #1;
            exp = exp_out(cls, ph[i], z);
            got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s instr=%h phase %0d: got %h expected %h", name, ins, ph[i], got, exp);
            end
        end
    endtask

    task automatic applyStimulus_reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        out_t got;
        bus.instr = 32'h0C000010;
        bus.zero  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            got = observe();
            n_tests++;
            if (got !== out_t'('0)) begin
                n_fail++;
                $display("[TB] FAIL reset_state cycle %0d: got %h expected %h", i, got, out_t'('0));
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_lui();
        run_instr(32'h3C011234, "lui", 99);
    endtask

    task automatic test_lw();
        run_instr(32'h8C220004, "lw", 99);
    endtask

    task automatic test_beq();
        out_t got;
        out_t exp;
        for (int k = 0; k < 2; k++) begin
            run_instr(32'h10220003, "beq", 2);
            @(negedge clk);
            bus.zero = (k == 0);
            #1;
            exp = exp_out(C_BEQ, P_E, (k == 0));
            got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL beq_exe zero=%0d: got %h expected %h", (k == 0), got, exp);
            end
        end
    endtask

    task automatic test_jal();
        run_instr(32'h0C000010, "jal", 99);
    endtask

    task automatic test_sw_abort();
        out_t got;
        out_t exp;
        run_instr(32'hAC220008, "sw_abort", 3);
        @(negedge clk);
        #1;
        exp = exp_out(C_SW, P_M, 1'b0);
        got = observe();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL sw_mem: got %h expected %h", got, exp);
        end
        #1 reset = 1'b1;
        #1;
        got = observe();
        n_tests++;
        if (got !== out_t'('0)) begin
            n_fail++;
            $display("[TB] FAIL sw_async_abort: got %h expected %h", got, out_t'('0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(gen_instr(C_LUI), "after_abort", 99);
    endtask

    task automatic test_illegal();
        out_t got;
        out_t exp;
        run_instr(32'hFC000000, "illegal", 99);
`ifdef MC_ILLEGAL_HALT_EN
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.zero = 1'($urandom);
            #1;
            exp = exp_out(C_BAD, P_H, 1'b0);
            got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL halt_hold cycle %0d: got %h expected %h", i, got, exp);
            end
        end
        applyStimulus_reset_pulse();
`else
        exp = exp_out(C_BAD, P_F, 1'b0);
        @(negedge clk);
        #1;
        got = observe();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL illegal_nop_return: got %h expected %h", got, exp);
        end
        @(posedge clk);
        #1;
        applyStimulus_reset_pulse();
`endif
    endtask

    task automatic test_random();
        int cls;
`ifdef MC_ILLEGAL_HALT_EN
        int top = C_JAL;
`else
        int top = C_BAD;
`endif
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, top);
            run_instr(gen_instr(cls), "random", 99);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.instr = 32'h0;
        bus.zero  = 1'b0;
        test_reset();
        test_lui();
        test_lw();
        test_beq();
        test_jal();
        test_sw_abort();
        test_random();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
